// File: rtl/mult_arbiter.sv
// Four-requester round-robin front end for a shared multi-cycle multiplier.
// Holds operands steady across the multiplier's sampling window and times out stuck operations.
module mult_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req_v,
  input  logic [127:0] req_a,
  input  logic [127:0] req_b,
  input  logic [7:0]   req_ww,
  output logic [3:0]   req_ack,
  output logic [3:0]   resp_v,
  output logic [63:0]  resp_data,
  output logic         resp_err,
  output logic         busy,
  output logic         mul_in_v,
  output logic [31:0]  mul_a,
  output logic [31:0]  mul_b,
  output logic [1:0]   mul_ww,
  input  logic         mul_ready,
  input  logic         mul_out_v,
  input  logic [63:0]  mul_out
);

  // state | meaning
  // IDLE  | pick a requester, ack it and latch its operands
  // ISSUE | present operands, launch when the multiplier is ready
  // WAIT  | wait for the product or the watchdog
  // RESP  | return result to the winner, advance round-robin pointer
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [1:0]  rr;
  logic [1:0]  winner;
  logic [7:0]  wd;
  logic        err_q;

  logic        found;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic        grant;
  logic        done_ok;
  logic        done_to;

  // first asserted requester at or after rr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = rr;
    idx   = rr;
    for (int k = 0; k < 4; k++) begin
      idx = rr + 2'(k);
      if (!found && req_v[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    req_ack  = 4'b0000;
    resp_v   = 4'b0000;
    mul_in_v = 1'b0;
    grant    = 1'b0;
    done_ok  = 1'b0;
    done_to  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant    = 1'b1;
          req_ack  = 4'b0001 << pick;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (mul_ready) begin
          mul_in_v = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        // the first WAIT cycle may still carry a stale product, so wd must be nonzero
        if (mul_out_v && (wd != 8'd0)) begin
          done_ok  = 1'b1;
          state_nx = RESP;
        end else if (wd == WD_LAST) begin
          done_to  = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        resp_v   = 4'b0001 << winner;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (reset) begin
      req_ack  = 4'b0000;
      resp_v   = 4'b0000;
      mul_in_v = 1'b0;
      grant    = 1'b0;
      done_ok  = 1'b0;
      done_to  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr        <= 2'd0;
      winner    <= 2'd0;
      mul_a     <= 32'd0;
      mul_b     <= 32'd0;
      mul_ww    <= 2'd0;
      wd        <= 8'd0;
      resp_data <= 64'd0;
      err_q     <= 1'b0;
    end else begin
      if (grant) begin
        winner <= pick;
        mul_a  <= req_a[{pick, 5'b00000} +: 32];
        mul_b  <= req_b[{pick, 5'b00000} +: 32];
        mul_ww <= req_ww[{pick, 1'b0} +: 2];
      end
      if (state == WAIT) wd <= wd + 8'd1;
      else               wd <= 8'd0;
      if (done_ok) begin
        resp_data <= mul_out;
        err_q     <= 1'b0;
      end else if (done_to) begin
        resp_data <= 64'd0;
        err_q     <= 1'b1;
      end
      if (state == RESP) rr <= winner + 2'd1;
    end
  end

  assign resp_err = err_q;
  assign busy     = (state != IDLE) && !reset;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: table of transactions against a small multiplier model,
// plus hand sequences for ready stalls, watchdog, late completion and mid-operation reset.
module tb_mult_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_v;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [7:0]   req_ww;
  logic [3:0]   req_ack;
  logic [3:0]   resp_v;
  logic [63:0]  resp_data;
  logic         resp_err;
  logic         busy;
  logic         mul_in_v;
  logic [31:0]  mul_a;
  logic [31:0]  mul_b;
  logic [1:0]   mul_ww;
  logic         mul_ready;
  logic         mul_out_v = 1'b0;
  logic [63:0]  mul_out = 64'd0;

  int checks = 0;
  int failures = 0;
  logic [63:0] last_data;

  logic [31:0] exp_a [4] = '{32'd3, 32'd7, 32'd11, 32'd13};
  logic [31:0] exp_b [4] = '{32'd5, 32'd9, 32'd6, 32'd17};

  always #5 clk = ~clk;

  mult_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_v(req_v), .req_a(req_a), .req_b(req_b),
    .req_ww(req_ww), .req_ack(req_ack), .resp_v(resp_v), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy), .mul_in_v(mul_in_v), .mul_a(mul_a),
    .mul_b(mul_b), .mul_ww(mul_ww), .mul_ready(mul_ready), .mul_out_v(mul_out_v),
    .mul_out(mul_out)
  );

  // multiplier model: product appears m_lat cycles after the launch edge; m_never stalls forever
  int          m_lat = 3;
  logic        m_never = 1'b0;
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_prod = 64'd0;

  always @(posedge clk) begin
    mul_out_v <= 1'b0;
    if (reset) begin
      m_busy <= 1'b0;
    end else if (mul_in_v && mul_ready) begin
      if (m_lat == 0) begin
        mul_out_v <= 1'b1;
        mul_out   <= 64'(mul_a) * 64'(mul_b);
      end else begin
        m_busy <= !m_never;
        m_cnt  <= m_lat;
        m_prod <= 64'(mul_a) * 64'(mul_b);
      end
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        mul_out_v <= 1'b1;
        mul_out   <= m_prod;
        m_busy    <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // one full transaction from request to response; call just after a rising edge with the DUT idle
  task automatic run_txn(input logic [3:0] rv, input int w, input logic [63:0] ed,
                         input logic ee, input int hold, input int elat);
    int ack_c = -1;
    int n_inv = 0;
    int inv_c = -1;
    int hl = 0;
    bit done = 0;
    bit unstable = 0;
    logic [3:0] oh;
    oh = 4'b0001 << w;
    req_v = rv;
    mul_ready = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (req_ack != 4'b0000) begin
        if (ack_c < 0) begin
          chk("ack", 64'(req_ack), 64'(oh));
          chk("resp_data_hold", resp_data, last_data);
          ack_c = c;
          hl = hold;
        end else begin
          chk("reack", 64'(req_ack), 64'd0);
        end
      end
      if (ack_c >= 0 && c > ack_c) begin
        if (mul_a !== exp_a[w] || mul_b !== exp_b[w] || mul_ww !== 2'(w)) unstable = 1;
      end
      if (mul_in_v) begin
        n_inv++;
        inv_c = c - ack_c;
      end
      if (resp_v != 4'b0000) begin
        done = 1;
        chk("resp_v", 64'(resp_v), 64'(oh));
        chk("resp_data", resp_data, ed);
        chk("resp_err", 64'(resp_err), 64'(ee));
        chk("latency", 64'(c - ack_c), 64'(elat));
        chk("mul_in_v_count", 64'(n_inv), 64'd1);
        chk("mul_in_v_cycle", 64'(inv_c), 64'(1 + hold));
        chk("operand_stable", 64'(unstable), 64'd0);
        chk("busy_resp", 64'(busy), 64'd1);
        last_data = ed;
      end
      @(posedge clk);
      #1;
      if (ack_c >= 0) begin
        if (hl > 0) begin
          mul_ready = 1'b0;
          hl--;
        end else begin
          mul_ready = 1'b1;
        end
      end
    end
    chk("txn_done", 64'(done), 64'd1);
    mul_ready = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ack"}, 64'(req_ack), 64'd0);
    chk({tag, "_resp_v"}, 64'(resp_v), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_mul_in_v"}, 64'(mul_in_v), 64'd0);
    chk({tag, "_mul_a"}, 64'(mul_a), 64'd0);
    chk({tag, "_mul_b"}, 64'(mul_b), 64'd0);
    chk({tag, "_mul_ww"}, 64'(mul_ww), 64'd0);
    chk({tag, "_resp_data"}, resp_data, 64'd0);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'd0);
  endtask

  typedef struct {
    logic [3:0]  rv;
    int          w;
    logic [63:0] d;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // round-robin pointer walk noted per row
    tbl[0]  = '{4'b0001, 0, 64'd15};
    tbl[1]  = '{4'b1000, 3, 64'd221};
    tbl[2]  = '{4'b1111, 0, 64'd15};
    tbl[3]  = '{4'b1111, 1, 64'd63};
    tbl[4]  = '{4'b1111, 2, 64'd66};
    tbl[5]  = '{4'b1111, 3, 64'd221};
    tbl[6]  = '{4'b1111, 0, 64'd15};
    tbl[7]  = '{4'b0001, 0, 64'd15};
    tbl[8]  = '{4'b1001, 3, 64'd221};
    tbl[9]  = '{4'b0110, 1, 64'd63};
    tbl[10] = '{4'b0011, 0, 64'd15};
    tbl[11] = '{4'b0100, 2, 64'd66};

    req_a     = {exp_a[3], exp_a[2], exp_a[1], exp_a[0]};
    req_b     = {exp_b[3], exp_b[2], exp_b[1], exp_b[0]};
    req_ww    = 8'b11_10_01_00;
    reset     = 1'b1;
    req_v     = 4'b1111;
    mul_ready = 1'b1;
    last_data = 64'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_txn(tbl[i].rv, tbl[i].w, tbl[i].d, 1'b0, 0, 3 + m_lat);

    run_txn(4'b0001, 0, 64'd15, 1'b0, 5, 11);

    m_never = 1'b1;
    run_txn(4'b0010, 1, 64'd0, 1'b1, 0, 18);
    m_never = 1'b0;

    m_lat = 0;
    run_txn(4'b0100, 2, 64'd0, 1'b1, 0, 18);

    m_lat = 15;
    run_txn(4'b1000, 3, 64'd221, 1'b0, 0, 18);

    m_lat = 1;
    run_txn(4'b0001, 0, 64'd15, 1'b0, 0, 4);

    req_v = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ack", 64'(req_ack), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_resp_v", 64'(resp_v), 64'd0);
    end
    @(posedge clk);
    #1;

    // abandon an operation mid-WAIT; pointer is 1 here, so requester 2 wins
    m_lat = 3;
    req_v = 4'b0100;
    @(negedge clk);
    chk("abort_ack", 64'(req_ack), 64'b0100);
    @(posedge clk);
    #1;
    req_v = 4'b0000;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    req_v = 4'b0011;
    @(negedge clk);
    chk("abort_resp_v", 64'(resp_v), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_zero("abort");
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_data = 64'd0;
    run_txn(4'b0011, 0, 64'd15, 1'b0, 0, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
